// File: rtl/instr_fetch_queue_pkg.sv
// Shared widths, defaults and FSM state encoding for the instruction fetch queue.
package instr_fetch_queue_pkg;

  localparam int FQ_ADDR_W   = 8;
  localparam int FQ_INSTR_W  = 10;
  localparam int FQ_DEPTH    = 4;
  localparam int FQ_RESET_PC = 0;

  typedef enum logic [1:0] {
    FQ_IDLE    = 2'd0,
    FQ_WAIT    = 2'd1,
    FQ_DISCARD = 2'd2
  } fq_state_e;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Bundle of the instruction-memory handshake, redirect and decode-side valid/ready signals.
interface instr_fetch_queue_if
  import instr_fetch_queue_pkg::*;
#(
  parameter int ADDR_W  = FQ_ADDR_W,
  parameter int INSTR_W = FQ_INSTR_W
) ();

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               ins_valid;
  logic               ins_ready;
  logic [INSTR_W-1:0] ins_out;
  logic [ADDR_W-1:0]  ins_pc;

  modport master (
    output imem_req, imem_addr, ins_valid, ins_out, ins_pc,
    input  imem_ack, imem_rdata, redirect, redirect_pc, ins_ready
  );

  modport slave (
    input  imem_req, imem_addr, ins_valid, ins_out, ins_pc,
    output imem_ack, imem_rdata, redirect, redirect_pc, ins_ready
  );

endinterface

// File: rtl/instr_fetch_queue_sync_fifo.sv
// Prefetch queue: synchronous FIFO with flush and a first-word-fall-through head.
module instr_fetch_queue_sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != FULL_CNT);
  assign do_pop  = pop && (count != '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Flush wins over a simultaneous push/pop so a redirect leaves the queue truly empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, runs the imem req/ack handshake and feeds decode
// from a small prefetch queue; a redirect flushes the queue and any in-flight word.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int                ADDR_W   = FQ_ADDR_W,
  parameter int                INSTR_W  = FQ_INSTR_W,
  parameter int                DEPTH    = FQ_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FQ_RESET_PC)
) (
  input logic                 clk,
  input logic                 reset,
  instr_fetch_queue_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fq_state_e                 state_q;
  fq_state_e                 state_d;
  logic [ADDR_W-1:0]         fetch_pc_q;
  logic [ADDR_W-1:0]         fetch_pc_d;
  logic [ADDR_W-1:0]         addr_q;
  logic [ADDR_W-1:0]         addr_d;
  logic [CNT_W-1:0]          count;
  logic [CNT_W-1:0]          count_after;
  logic                      push;
  logic                      pop;
  logic                      ins_valid;
  logic                      has_entry;
  logic [ADDR_W+INSTR_W-1:0] head;

  assign has_entry   = (count != '0);
  assign ins_valid   = has_entry && !bus.redirect;
  assign pop         = ins_valid && bus.ins_ready;
  assign count_after = pop ? count : count + CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FQ_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  // addr_q is kept apart from fetch_pc so a DISCARD keeps presenting the abandoned
  // address while fetch_pc already points at the redirect target.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    push       = 1'b0;
    unique case (state_q)
      FQ_IDLE: begin
        if (bus.redirect) begin
          fetch_pc_d = bus.redirect_pc;
        end else if (count < FULL_CNT) begin
          state_d = FQ_WAIT;
          addr_d  = fetch_pc_q;
        end
      end
      FQ_WAIT: begin
        if (bus.redirect) begin
          fetch_pc_d = bus.redirect_pc;
          state_d    = bus.imem_ack ? FQ_IDLE : FQ_DISCARD;
        end else if (bus.imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + ADDR_W'(1);
          addr_d     = fetch_pc_q + ADDR_W'(1);
          if (count_after >= FULL_CNT) begin
            state_d = FQ_IDLE;
          end
        end
      end
      FQ_DISCARD: begin
        if (bus.redirect) begin
          fetch_pc_d = bus.redirect_pc;
        end
        // Once the stale request completes it is over; a same-cycle redirect only moves fetch_pc.
        if (bus.imem_ack) begin
          state_d = FQ_IDLE;
        end
      end
      default: state_d = FQ_IDLE;
    endcase
  end

  instr_fetch_queue_sync_fifo #(
    .WIDTH (ADDR_W + INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect),
    .wdata ({fetch_pc_q, bus.imem_rdata}),
    .rdata (head),
    .count (count)
  );

  assign bus.imem_req  = (state_q != FQ_IDLE);
  assign bus.imem_addr = addr_q;
  assign bus.ins_valid = ins_valid;
  assign bus.ins_pc    = has_entry ? head[ADDR_W+INSTR_W-1 -: ADDR_W] : '0;
  assign bus.ins_out   = has_entry ? head[INSTR_W-1:0] : '0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a wait-state memory responder, a stream-level
// reference model checked every cycle, and hand-computed expectations per scenario.
module tb_instr_fetch_queue;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 10;
  localparam int DEPTH   = 4;

  logic clk = 1'b0;
  logic reset;

  int total = 0;
  int bad   = 0;

  int   mem_wait  = 0;
  logic ack_force = 1'b0;
  int   waited    = 0;

  int                 occ       = 0;
  logic               tainted   = 1'b0;
  logic [ADDR_W-1:0]  exp_pc    = '0;
  logic [ADDR_W-1:0]  exp_fetch = '0;
  logic [ADDR_W-1:0]  popped_pc[$];
  logic [INSTR_W-1:0] popped_ins[$];

  instr_fetch_queue_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  instr_fetch_queue #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (8'h00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory contents are a fixed function of the address, so any word can be predicted.
  function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a, 2'b11} ^ 10'h155;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic note_timeout(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got no event within cycle budget, required event", name);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input logic rd, input logic [ADDR_W-1:0] rpc, input logic rdy);
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.ins_ready   = rdy;
    step();
    bus.redirect    = 1'b0;
  endtask

  // Memory responder: acks after mem_wait idle cycles, or every cycle when ack_force is set.
  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (ack_force) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(bus.imem_addr);
      end else if (bus.imem_req) begin
        if (waited >= mem_wait) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = mem_word(bus.imem_addr);
          waited         = 0;
        end else begin
          bus.imem_ack = 1'b0;
          waited++;
        end
      end else begin
        bus.imem_ack = 1'b0;
        waited       = 0;
      end
    end
  end

  // Stream model: decode must see consecutive PCs from the last restart point, each
  // carrying its memory word; occupancy follows accepted acks and pops.
  initial begin
    logic exp_valid;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check_output("reset_req", bus.imem_req, 0);
        check_output("reset_valid", bus.ins_valid, 0);
        check_output("reset_ins_out", bus.ins_out, 0);
        check_output("reset_ins_pc", bus.ins_pc, 0);
        check_output("reset_addr", bus.imem_addr, 0);
        occ       = 0;
        tainted   = 1'b0;
        exp_pc    = 8'h00;
        exp_fetch = 8'h00;
      end else begin
        exp_valid = (occ != 0) && !bus.redirect;
        check_output("valid", bus.ins_valid, exp_valid);
        if (exp_valid) begin
          check_output("head_pc", bus.ins_pc, exp_pc);
          check_output("head_ins", bus.ins_out, mem_word(exp_pc));
        end
        if (occ >= DEPTH) begin
          check_output("full_no_req", bus.imem_req, 0);
        end
        if (bus.redirect) begin
          occ       = 0;
          exp_pc    = bus.redirect_pc;
          exp_fetch = bus.redirect_pc;
          tainted   = bus.imem_req && !bus.imem_ack;
        end else begin
          if (exp_valid && bus.ins_ready) begin
            popped_pc.push_back(bus.ins_pc);
            popped_ins.push_back(bus.ins_out);
            occ--;
            exp_pc++;
          end
          if (bus.imem_req && bus.imem_ack) begin
            if (tainted) begin
              tainted = 1'b0;
            end else begin
              check_output("fetch_addr", bus.imem_addr, exp_fetch);
              occ++;
              exp_fetch++;
            end
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no end of test, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic [ADDR_W-1:0] old_addr;

    reset           = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.ins_ready   = 1'b1;
    #1 reset = 1'b0;
    step();
    step();
    check_output("rst_hold_req", bus.imem_req, 0);
    check_output("rst_hold_valid", bus.ins_valid, 0);
    #1 reset = 1'b1;

    // 1: zero-wait memory, decode always ready
    step();
    check_output("t1_first_req", bus.imem_req, 1);
    check_output("t1_first_addr", bus.imem_addr, 8'h00);
    check_output("t1_valid_before_ack", bus.ins_valid, 0);
    step();
    check_output("t1_valid_after_ack", bus.ins_valid, 1);
    check_output("t1_first_ins", bus.ins_out, 10'h156);
    n = 0;
    while (popped_pc.size() < 4 && n < 20) begin step(); n++; end
    if (popped_pc.size() >= 4) begin
      for (int i = 0; i < 4; i++) check_output($sformatf("t1_pc%0d", i), popped_pc[i], i);
    end else note_timeout("t1_stream");

    // 2: decode stalled, ack tied high: queue fills to four and requests stop
    ack_force = 1'b1;
    apply_stimulus(1'b1, 8'h00, 1'b0);
    repeat (8) step();
    for (int i = 0; i < 3; i++) begin
      check_output("t2_full_req_low", bus.imem_req, 0);
      step();
    end
    check_output("t2_full_valid", bus.ins_valid, 1);
    check_output("t2_full_head", bus.ins_pc, 8'h00);
    popped_pc.delete();
    popped_ins.delete();
    apply_stimulus(1'b0, 8'h00, 1'b1);
    bus.ins_ready = 1'b0;
    check_output("t2_one_pop", popped_pc.size(), 1);
    step();
    check_output("t2_refetch_req", bus.imem_req, 1);
    check_output("t2_refetch_addr", bus.imem_addr, 8'h04);
    step();
    ack_force = 1'b0;

    // 3: two wait states, redirect while a request is outstanding
    mem_wait      = 2;
    bus.ins_ready = 1'b1;
    n = 0;
    while (!(bus.imem_req && !bus.imem_ack) && n < 30) begin step(); n++; end
    if (n >= 30) note_timeout("t3_find_wait");
    old_addr = bus.imem_addr;
    popped_pc.delete();
    popped_ins.delete();
    apply_stimulus(1'b1, 8'h40, 1'b1);
    check_output("t3_discard_req", bus.imem_req, 1);
    check_output("t3_discard_addr", bus.imem_addr, old_addr);
    n = 0;
    while (bus.imem_req && n < 10) begin step(); n++; end
    if (n >= 10) note_timeout("t3_discard_end");
    n = 0;
    while (!bus.imem_req && n < 10) begin step(); n++; end
    check_output("t3_new_addr", bus.imem_addr, 8'h40);
    n = 0;
    while (popped_pc.size() < 1 && n < 20) begin step(); n++; end
    if (popped_pc.size() >= 1) begin
      check_output("t3_first_pc", popped_pc[0], 8'h40);
      check_output("t3_first_ins", popped_ins[0], 10'h056);
    end else note_timeout("t3_stream");

    // 4: redirect coinciding with ack and a would-be pop
    mem_wait = 0;
    n = 0;
    while (!(bus.imem_req && bus.imem_ack && bus.ins_valid) && n < 20) begin step(); n++; end
    if (n >= 20) note_timeout("t4_find_busy");
    popped_pc.delete();
    popped_ins.delete();
    apply_stimulus(1'b1, 8'h10, 1'b1);
    check_output("t4_no_pop", popped_pc.size(), 0);
    check_output("t4_empty", bus.ins_valid, 0);
    check_output("t4_idle_req", bus.imem_req, 0);
    step();
    check_output("t4_next_addr", bus.imem_addr, 8'h10);
    n = 0;
    while (popped_pc.size() < 1 && n < 20) begin step(); n++; end
    if (popped_pc.size() >= 1) check_output("t4_first_pc", popped_pc[0], 8'h10);
    else note_timeout("t4_stream");

    // 5: redirect near the top of the address space, PC wraps
    popped_pc.delete();
    popped_ins.delete();
    apply_stimulus(1'b1, 8'hFE, 1'b1);
    n = 0;
    while (popped_pc.size() < 4 && n < 20) begin step(); n++; end
    if (popped_pc.size() >= 4) begin
      check_output("t5_pc0", popped_pc[0], 8'hFE);
      check_output("t5_pc1", popped_pc[1], 8'hFF);
      check_output("t5_pc2", popped_pc[2], 8'h00);
      check_output("t5_pc3", popped_pc[3], 8'h01);
    end else note_timeout("t5_stream");

    // 6: reset asserted mid-request with three words queued
    mem_wait = 2;
    apply_stimulus(1'b1, 8'h20, 1'b0);
    n = 0;
    while (!(occ == 3 && bus.imem_req && !bus.imem_ack) && n < 60) begin step(); n++; end
    if (n >= 60) note_timeout("t6_fill");
    reset = 1'b0;
    #1;
    check_output("t6_req_drop", bus.imem_req, 0);
    check_output("t6_valid_drop", bus.ins_valid, 0);
    step();
    #1 reset = 1'b1;
    step();
    check_output("t6_restart_req", bus.imem_req, 1);
    check_output("t6_restart_addr", bus.imem_addr, 8'h00);
    check_output("t6_restart_empty", bus.ins_valid, 0);
    mem_wait      = 0;
    bus.ins_ready = 1'b1;
    popped_pc.delete();
    popped_ins.delete();
    n = 0;
    while (popped_pc.size() < 1 && n < 20) begin step(); n++; end
    if (popped_pc.size() >= 1) begin
      check_output("t6_first_pc", popped_pc[0], 8'h00);
      check_output("t6_first_ins", popped_ins[0], 10'h156);
    end else note_timeout("t6_stream");

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
